// File: rtl/branch_pred_ctrl_if.sv
// Fetch/execute-side signal bundle between the pipeline and the branch predictor.
// The pipeline takes the master modport and the predictor takes the slave modport.
interface branch_pred_ctrl_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] fetch_pc;
  logic            pred_taken_f;
  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_stall;
  logic [PC_W-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output fetch_pc, ex_valid, ex_is_branch, ex_stall, ex_pc,
           ex_pred_taken, ex_taken, ex_target,
    input  pred_taken_f, mispredict, redirect_pc
  );

  modport slave (
    input  fetch_pc, ex_valid, ex_is_branch, ex_stall, ex_pc,
           ex_pred_taken, ex_taken, ex_target,
    output pred_taken_f, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// 2-bit saturating-counter BHT with zero-latency lookup and execute-stage mispredict/redirect.
// Optional macro BP_STATS_EN adds saturating branch_cnt / mispred_cnt outputs.
module branch_pred_ctrl #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_pred_ctrl_if.slave    bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispred_cnt
`endif
);

  localparam int unsigned ENTRIES  = 2 ** IDX_W;
  localparam logic [1:0]  CNT_INIT = 2'b01;

  logic [1:0]       bht [ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_cnt;
  logic [1:0]       ex_cnt_next;
  logic             res;
  logic             unused_pc_bits;

  assign fetch_idx      = bus.fetch_pc[IDX_W+1:2];
  assign ex_idx         = bus.ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.fetch_pc[PC_W-1:IDX_W+2], bus.fetch_pc[1:0]};

  // Lookup reads the array directly, so a same-cycle update is not visible until the edge.
  assign bus.pred_taken_f = bht[fetch_idx][1];

  // Resolve, mispredict and redirect target
  always_comb begin
    res             = 1'b0;
    bus.mispredict  = 1'b0;
    bus.redirect_pc = '0;
    res = bus.ex_valid & bus.ex_is_branch & ~bus.ex_stall;
    if (res && (bus.ex_pred_taken != bus.ex_taken)) begin
      bus.mispredict  = 1'b1;
      bus.redirect_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + PC_W'(4));
    end
  end

  // Saturating counter step for the resolving entry
  always_comb begin
    ex_cnt      = bht[ex_idx];
    ex_cnt_next = ex_cnt;
    if (bus.ex_taken) begin
      if (ex_cnt != 2'b11) ex_cnt_next = ex_cnt + 2'd1;
    end else begin
      if (ex_cnt != 2'b00) ex_cnt_next = ex_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        bht[i] <= CNT_INIT;
      end
    end else if (res) begin
      bht[ex_idx] <= ex_cnt_next;
    end
  end

`ifdef BP_STATS_EN
  // Event counters hold at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      if (res && (branch_cnt != 32'hFFFF_FFFF)) begin
        branch_cnt <= branch_cnt + 32'd1;
      end
      if (bus.mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed bench for branch_pred_ctrl: lookup, training, saturation, stall, bubbles,
// aliasing, PC wrap, same-cycle read ordering, async reset and optional stats counters.
module tb_branch_pred_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  branch_pred_ctrl_if #(.PC_W(32)) bus ();

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;
`endif

  branch_pred_ctrl #(.IDX_W(4), .PC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef BP_STATS_EN
    ,
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic ex_drive(input logic v, input logic br, input logic st, input logic [31:0] pc,
                          input logic p, input logic t, input logic [31:0] tgt);
    bus.ex_valid      = v;
    bus.ex_is_branch  = br;
    bus.ex_stall      = st;
    bus.ex_pc         = pc;
    bus.ex_pred_taken = p;
    bus.ex_taken      = t;
    bus.ex_target     = tgt;
  endtask

  task automatic ex_idle();
    ex_drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with EX idle; checks the prediction one cycle later
  task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
    @(negedge clk);
    bus.fetch_pc = pc;
    #1;
    check(tag, 32'(bus.pred_taken_f), 32'(exp));
  endtask

  // Present one resolving branch for a cycle, check its outputs, let it train
  task automatic resolve(input string tag, input logic [31:0] pc, input logic p, input logic t,
                         input logic [31:0] tgt, input logic exp_mis, input logic [31:0] exp_redir);
    ex_drive(1'b1, 1'b1, 1'b0, pc, p, t, tgt);
    #1;
    check({tag, "_mis"}, 32'(bus.mispredict), 32'(exp_mis));
    check({tag, "_redir"}, bus.redirect_pc, exp_redir);
    next_cycle();
    ex_idle();
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    clk          = 1'b0;
    reset        = 1'b1;
    bus.fetch_pc = 32'h0;
    ex_idle();

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_pred", 32'(bus.pred_taken_f), 32'd0);
    check("reset_mis", 32'(bus.mispredict), 32'd0);
    check("reset_redir", bus.redirect_pc, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      pred_at($sformatf("sweep_%0d", i), 32'(i * 4), 1'b0);
    end

    // 01 -> 10 on a mispredicted taken branch
    @(negedge clk);
    resolve("br1", 32'h10, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40);
    pred_at("br1_pred", 32'h10, 1'b1);

    // Saturate at 11, then step down one at a time
    for (int i = 0; i < 3; i++) begin
      resolve($sformatf("br_t%0d", i), 32'h10, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    end
    resolve("br_nt", 32'h10, 1'b1, 1'b0, 32'h40, 1'b1, 32'h14);
    pred_at("sat_pred", 32'h10, 1'b1);
    @(negedge clk);
    resolve("br_nt2", 32'h10, 1'b1, 1'b0, 32'h40, 1'b1, 32'h14);
    pred_at("weak_nt", 32'h10, 1'b0);

    // Mispredicted branch held by a 3-cycle stall
    @(negedge clk);
    bus.fetch_pc = 32'h10;
    ex_drive(1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d_mis", i), 32'(bus.mispredict), 32'd0);
      check($sformatf("stall%0d_redir", i), bus.redirect_pc, 32'h0);
      check($sformatf("stall%0d_pred", i), 32'(bus.pred_taken_f), 32'd0);
      next_cycle();
    end
    bus.ex_stall = 1'b0;
    #1;
    check("release_mis", 32'(bus.mispredict), 32'd1);
    check("release_redir", bus.redirect_pc, 32'h80);
    next_cycle();
    ex_idle();
    #1;
    check("release_after_mis", 32'(bus.mispredict), 32'd0);
    check("release_pred", 32'(bus.pred_taken_f), 32'd1);
    // 10 -> 01 proves only one update happened during the stall
    resolve("post_stall", 32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 32'h14);
    pred_at("one_update", 32'h10, 1'b0);

    // Bubble and non-branch leave everything alone
    @(negedge clk);
    ex_drive(1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 32'h40);
    #1;
    check("bubble_mis", 32'(bus.mispredict), 32'd0);
    check("bubble_redir", bus.redirect_pc, 32'h0);
    next_cycle();
    ex_drive(1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 1'b1, 32'h40);
    #1;
    check("nonbr_mis", 32'(bus.mispredict), 32'd0);
    next_cycle();
    ex_idle();
    pred_at("bubble_pred", 32'h10, 1'b0);

    // 0x50 and 0x10 share index 4
    @(negedge clk);
    resolve("alias", 32'h50, 1'b0, 1'b1, 32'h90, 1'b1, 32'h90);
    pred_at("alias_10", 32'h10, 1'b1);
    pred_at("alias_50", 32'h50, 1'b1);

    // Not-taken fallthrough wraps to 0; entry 15 floors at 00
    @(negedge clk);
    resolve("wrap", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    resolve("wrap_t", 32'h3C, 1'b0, 1'b1, 32'h100, 1'b1, 32'h100);
    pred_at("wrap_floor", 32'h3C, 1'b0);

    // Same-cycle lookup sees the old counter
    @(negedge clk);
    bus.fetch_pc = 32'h20;
    ex_drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 32'h60);
    #1;
    check("same_cycle_old", 32'(bus.pred_taken_f), 32'd0);
    check("same_cycle_mis", 32'(bus.mispredict), 32'd1);
    @(posedge clk);
    #1;
    check("same_cycle_new", 32'(bus.pred_taken_f), 32'd1);
    @(negedge clk);
    ex_idle();

    // Async reset with a pending update: entry 0x10 is at 10 before reset
    @(negedge clk);
    bus.fetch_pc = 32'h10;
    ex_drive(1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 32'h40);
    #1;
    check("pre_rst_pred", 32'(bus.pred_taken_f), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_pred", 32'(bus.pred_taken_f), 32'd0);
    @(posedge clk);
    @(negedge clk);
    ex_idle();
    reset = 1'b0;
    #1;
    check("post_rst_10", 32'(bus.pred_taken_f), 32'd0);
    bus.fetch_pc = 32'h20;
    #1;
    check("post_rst_20", 32'(bus.pred_taken_f), 32'd0);
    resolve("after_rst", 32'h10, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40);
    pred_at("rst_to_01", 32'h10, 1'b1);

`ifdef BP_STATS_EN
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("stats_rst_br", branch_cnt, 32'd0);
    check("stats_rst_mis", mispred_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // Stalled and bubble cycles must not count
    ex_drive(1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 1'b0, 32'h0);
    next_cycle();
    ex_drive(1'b0, 1'b1, 1'b0, 32'h04, 1'b1, 1'b0, 32'h0);
    next_cycle();
    ex_idle();
    resolve("st0", 32'h00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve("st1", 32'h04, 1'b1, 1'b0, 32'h0, 1'b1, 32'h08);
    resolve("st2", 32'h08, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve("st3", 32'h0C, 1'b0, 1'b1, 32'h30, 1'b1, 32'h30);
    resolve("st4", 32'h00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("stats_br", branch_cnt, 32'd5);
    check("stats_mis", mispred_cnt, 32'd2);
    reset = 1'b1;
    #1;
    check("stats_midrst_br", branch_cnt, 32'd0);
    check("stats_midrst_mis", mispred_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
- Dynamic branch-direction predictor and misprediction controller for the 5-stage pipeline.
- Owns a branch history table (BHT) of 2-bit saturating counters, indexed by PC and looked up at fetch. Decode uses the predicted direction, since the branch target is known there.
- When the execute-stage branch outcome (BranchD) resolves, the block compares it with the prediction carried down the pipe. On a mismatch it issues a flush plus redirect PC, then trains the BHT.

Parameters:
- IDX_W, 4, BHT index width; table holds 2**IDX_W entries.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_pc  in  PC_W  PC being fetched (BHT lookup address)
- pred_taken_f  out  1  predicted direction for fetch_pc (combinational)
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_stall  in  1  EX stage held this cycle
- ex_pc  in  PC_W  PC of EX instruction
- ex_pred_taken  in  1  prediction made for this instruction at fetch, piped to EX
- ex_taken  in  1  actual outcome (BranchD from the branching unit)
- ex_target  in  PC_W  computed branch target
- mispredict  out  1  flush IF/ID and ID/EX this cycle
- redirect_pc  out  PC_W  PC to load when mispredict=1, else 0

Behaviour:
- Index: idx = pc[IDX_W+1:2]. Bits [1:0] are ignored; aliasing is accepted.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff bit1=1.
- Reset: all BHT entries go to 01 asynchronously. pred_taken_f=0 for every PC while reset is high and immediately after.
- Lookup: pred_taken_f is combinational from the BHT (0 latency). A read at the same index as a same-cycle update returns the old value; there is no bypass.
- Resolve condition: res = ex_valid & ex_is_branch & !ex_stall.
- mispredict = res & (ex_pred_taken != ex_taken). It is combinational in the same cycle as EX.
- redirect_pc:
  - ex_taken=1: ex_target.
  - ex_taken=0: ex_pc+4, computed modulo 2**PC_W so that all-ones-minus-3 wraps to 0.
  - When mispredict=0: redirect_pc=0.
- Training, on the rising clk edge when res=1, for entry idx(ex_pc):
  - ex_taken=1: increment, saturating at 11.
  - ex_taken=0: decrement, saturating at 00.
  - Training happens whether or not the branch was mispredicted.
- Stall: while ex_stall=1 there is no mispredict and no update. The branch resolves exactly once, in the cycle the stall drops.
- Bubbles and non-branches (ex_valid=0 or ex_is_branch=0): no mispredict, no update, regardless of ex_taken.
- Reset mid-operation: BHT returns to all-01 asynchronously. A pending update in that cycle is discarded.
- Only one update per cycle. The block is pure state, no FSM beyond per-entry counters. Timing is fixed: 0-cycle lookup, 1-cycle update latency.

Optional Feature:
- Macro BP_STATS_EN.
- Defined: adds outputs branch_cnt (out, 32) and mispred_cnt (out, 32).
  - branch_cnt increments on each res=1 edge.
  - mispred_cnt increments on each edge where mispredict=1.
  - Both saturate at 32'hFFFFFFFF and reset asynchronously to 0.
- Not defined: the ports and counters are absent. Core behaviour is identical in both cases.

Test Plan:
- Reset, then sweep fetch_pc 0x00..0x3C step 4 -> pred_taken_f=0 for all 16 entries.
- Branch at ex_pc=0x10, ex_pred_taken=0, ex_taken=1, ex_target=0x40 -> mispredict=1, redirect_pc=0x40 that cycle. Next cycle fetch_pc=0x10 gives pred_taken_f=1 (entry 10).
- Same branch resolved taken 3 more times -> entry saturates at 11. One not-taken with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x14, entry=10, prediction still taken.
- ex_stall=1 for 3 cycles with a mispredicted branch held in EX -> mispredict=0 and no counter change. On the stall-release cycle -> exactly one mispredict pulse and one update.
- ex_valid=0 with ex_is_branch=1 and ex_taken=1 -> mispredict=0, BHT unchanged. ex_pc=0x50 aliases with 0x10 (IDX_W=4) -> both share one counter.
- BP_STATS_EN defined: 5 branches with 2 mispredicts -> branch_cnt=5, mispred_cnt=2. Assert reset mid-run -> both read 0 immediately.
